// File: rtl/jtbubl_snd_post.sv
// jtbubl_snd_post
// Post-processing stage for the sound core output. Each new sample (a rising
// edge on sample_in) goes through four steps. The FSM captures it, removes DC
// with a single-pole high-pass filter, applies the fx-level gain with
// saturation, and scales it by a click-free volume ramp. The result is then
// handed to the mixer with its own one-cycle strobe. One sample is in flight
// at a time, and the add stage is shared between the HPF and GAIN steps.
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous reset, active low
//   snd_in     signed 16-bit sample from the sound core
//   sample_in  new-sample indicator (rising edge = new sample)
//   fxlevel    gain select: 0 x0.5, 1 x1, 2 x1.5, 3 x2
//   enable     1 ramps volume up to unity, 0 ramps it down to silence
//   snd_out    signed processed sample, held between samples
//   sample_out one-cycle pulse when snd_out updates
//   clip       one-cycle pulse with sample_out if HPF or GAIN saturated
//   overrun    one-cycle pulse when a sample edge arrives while busy
module jtbubl_snd_post #(
    parameter int DCW        = 8,
    parameter bit BYPASS_HPF = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] snd_in,
    input  logic        sample_in,
    input  logic [1:0]  fxlevel,
    input  logic        enable,
    output logic [15:0] snd_out,
    output logic        sample_out,
    output logic        clip,
    output logic        overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HPF  = 2'd1,
        ST_GAIN = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               sample_in_r;
    logic               edge_s;
    logic signed [15:0] xr_r;
    logic signed [15:0] x1_r;
    logic signed [15:0] y1_r;
    logic signed [15:0] g_r;
    logic        [4:0]  vol_r;
    logic               sat_r;
    logic signed [17:0] add_a_s;
    logic signed [17:0] add_b_s;
    logic signed [17:0] sum_s;
    logic signed [15:0] y_s;
    logic               hpf_sat_s;
    logic signed [19:0] g_ext_s;
    logic signed [19:0] vol_ext_s;
    logic signed [19:0] prod_s;
    logic        [3:0]  unused_prod_lsb_s;
    logic        [3:0]  unused_prod_msb_s;

    function automatic logic signed [17:0] sext18(input logic signed [15:0] v);
        sext18 = {{2{v[15]}}, v};
    endfunction

    // True when an 18-bit value does not fit in 16 signed bits
    function automatic logic ovf16(input logic signed [17:0] v);
        ovf16 = !((v[17:15] == 3'b000) || (v[17:15] == 3'b111));
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (!ovf16(v)) begin
            sat16 = v[15:0];
        end else if (v[17]) begin
            sat16 = 16'sh8000;
        end else begin
            sat16 = 16'sh7FFF;
        end
    endfunction

    assign edge_s = sample_in & ~sample_in_r;

    // Shared adder: the operand selection depends on the current step
    always_comb begin
        add_a_s = 18'sd0;
        add_b_s = 18'sd0;
        case (state_r)
            ST_HPF: begin
                add_a_s = sext18(xr_r) - sext18(x1_r);
                add_b_s = sext18(y1_r) - sext18(y1_r >>> DCW);
            end
            ST_GAIN: begin
                // y1_r already holds this sample's HPF output
                case (fxlevel)
                    2'd0: begin
                        add_a_s = sext18(y1_r >>> 1);
                        add_b_s = 18'sd0;
                    end
                    2'd1: begin
                        add_a_s = sext18(y1_r);
                        add_b_s = 18'sd0;
                    end
                    2'd2: begin
                        add_a_s = sext18(y1_r);
                        add_b_s = sext18(y1_r >>> 1);
                    end
                    2'd3: begin
                        // y <<< 1 computed as y + y
                        add_a_s = sext18(y1_r);
                        add_b_s = sext18(y1_r);
                    end
                    default: begin
                        add_a_s = 18'sd0;
                        add_b_s = 18'sd0;
                    end
                endcase
            end
            default: begin
                add_a_s = 18'sd0;
                add_b_s = 18'sd0;
            end
        endcase
    end

    assign sum_s = add_a_s + add_b_s;

    // HPF result, or the raw sample when the filter is bypassed
    always_comb begin
        if (BYPASS_HPF) begin
            y_s       = xr_r;
            hpf_sat_s = 1'b0;
        end else begin
            y_s       = sat16(sum_s);
            hpf_sat_s = ovf16(sum_s);
        end
    end

    // Volume scaling: |g*16| fits exactly in 20 signed bits
    assign g_ext_s           = {{4{g_r[15]}}, g_r};
    assign vol_ext_s         = {15'd0, vol_r};
    assign prod_s            = g_ext_s * vol_ext_s;
    assign unused_prod_lsb_s = prod_s[3:0];
    assign unused_prod_msb_s = prod_s[19:16];

    // Next-state logic: a fixed four-step walk started by a sample edge
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (edge_s) begin
                    state_s = ST_HPF;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HPF:  state_s = ST_GAIN;
            ST_GAIN: state_s = ST_OUT;
            ST_OUT:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath registers, FSM state and output pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            sample_in_r <= 1'b0;
            xr_r        <= 16'sd0;
            x1_r        <= 16'sd0;
            y1_r        <= 16'sd0;
            g_r         <= 16'sd0;
            vol_r       <= 5'd0;
            sat_r       <= 1'b0;
            snd_out     <= 16'd0;
            sample_out  <= 1'b0;
            clip        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_r     <= state_s;
            sample_in_r <= sample_in;
            sample_out  <= 1'b0;
            clip        <= 1'b0;
            overrun     <= edge_s & (state_r != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (edge_s) begin
                        xr_r  <= snd_in;
                        sat_r <= 1'b0;
                    end
                end
                ST_HPF: begin
                    x1_r  <= xr_r;
                    y1_r  <= y_s;
                    sat_r <= hpf_sat_s;
                end
                ST_GAIN: begin
                    g_r   <= sat16(sum_s);
                    sat_r <= sat_r | ovf16(sum_s);
                end
                ST_OUT: begin
                    snd_out    <= prod_s[19:4];
                    sample_out <= 1'b1;
                    clip       <= sat_r;
                    // The volume steps once per output sample, after it is used
                    if (enable) begin
                        if (vol_r < 5'd16) begin
                            vol_r <= vol_r + 5'd1;
                        end
                    end else if (vol_r > 5'd0) begin
                        vol_r <= vol_r - 5'd1;
                    end
                end
                default: begin
                    sat_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtbubl_snd_post.sv
// Bench for jtbubl_snd_post: two instances (HPF active and HPF bypassed) share
// one stimulus stream and are checked every cycle against a sample-level
// reference model, plus fixed expected values for the documented scenarios.
module tb_jtbubl_snd_post;

    logic        clk;
    logic        rstn;
    logic [15:0] snd_in;
    logic        sample_in;
    logic [1:0]  fxlevel;
    logic        enable;
    logic [15:0] snd_out0, snd_out1;
    logic        so0, so1, clip0, clip1, ov0, ov1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    jtbubl_snd_post #(.DCW(8), .BYPASS_HPF(1'b0)) u_hpf (
        .clk(clk), .rstn(rstn), .snd_in(snd_in), .sample_in(sample_in),
        .fxlevel(fxlevel), .enable(enable), .snd_out(snd_out0),
        .sample_out(so0), .clip(clip0), .overrun(ov0)
    );

    jtbubl_snd_post #(.DCW(8), .BYPASS_HPF(1'b1)) u_byp (
        .clk(clk), .rstn(rstn), .snd_in(snd_in), .sample_in(sample_in),
        .fxlevel(fxlevel), .enable(enable), .snd_out(snd_out1),
        .sample_out(so1), .clip(clip1), .overrun(ov1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model (sample level) ----------------
    int k;
    int vol_m;
    int x1_m [2];
    int y1_m [2];
    bit prev_in;
    bit pend;
    int pend_k;
    int pend_out [2];
    bit pend_clip [2];
    int exp_snd [2];
    bit exp_clip [2];
    bit exp_so;
    bit exp_ovr;

    // observations
    int last_out [2];
    bit last_clip [2];
    int so_cnt;
    int ov_cnt;

    function automatic int fdiv(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        vol_m = 0;
        prev_in = 1'b0;
        pend = 1'b0;
        for (int b = 0; b < 2; b++) begin
            x1_m[b] = 0;
            y1_m[b] = 0;
            exp_snd[b] = 0;
            exp_clip[b] = 1'b0;
        end
        exp_so = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic process(input int b, input int x, output int o, output bit c);
        int acc, y, gr, g;
        bit hs;
        if (b == 1) begin
            y = x;
            hs = 1'b0;
        end else begin
            acc = x - x1_m[b] + y1_m[b] - fdiv(y1_m[b], 256);
            y = clamp16(acc);
            hs = (y != acc);
        end
        x1_m[b] = x;
        y1_m[b] = y;
        case (fxlevel)
            2'd0: gr = fdiv(y, 2);
            2'd1: gr = y;
            2'd2: gr = y + fdiv(y, 2);
            default: gr = 2 * y;
        endcase
        g = clamp16(gr);
        o = fdiv(g * vol_m, 16);
        c = hs | (g != gr);
    endtask

    task automatic step();
        bit edge_m, busy;
        int x;
        @(posedge clk);
        #1;
        k++;
        exp_so = 1'b0;
        exp_ovr = 1'b0;
        exp_clip[0] = 1'b0;
        exp_clip[1] = 1'b0;
        if (!rstn) begin
            model_reset();
        end else begin
            edge_m = sample_in && !prev_in;
            prev_in = sample_in;
            busy = pend;
            if (pend && k == pend_k + 3) begin
                exp_so = 1'b1;
                for (int b = 0; b < 2; b++) begin
                    exp_snd[b] = pend_out[b];
                    exp_clip[b] = pend_clip[b];
                end
                pend = 1'b0;
            end
            if (edge_m) begin
                if (busy) begin
                    exp_ovr = 1'b1;
                end else begin
                    x = int'($signed(snd_in));
                    for (int b = 0; b < 2; b++) process(b, x, pend_out[b], pend_clip[b]);
                    if (enable && vol_m < 16) vol_m++;
                    else if (!enable && vol_m > 0) vol_m--;
                    pend = 1'b1;
                    pend_k = k;
                end
            end
        end
        check_val("snd_out0", snd_out0, 32'(exp_snd[0] & 16'hFFFF));
        check_val("snd_out1", snd_out1, 32'(exp_snd[1] & 16'hFFFF));
        check_val("sample_out0", so0, exp_so);
        check_val("sample_out1", so1, exp_so);
        check_val("clip0", clip0, exp_clip[0]);
        check_val("clip1", clip1, exp_clip[1]);
        check_val("overrun0", ov0, exp_ovr);
        check_val("overrun1", ov1, exp_ovr);
        if (so0 === 1'b1) begin
            last_out[0] = int'(snd_out0);
            last_clip[0] = clip0;
        end
        if (so1 === 1'b1) begin
            last_out[1] = int'(snd_out1);
            last_clip[1] = clip1;
        end
        if (so0 === 1'b1) so_cnt++;
        if (ov0 === 1'b1) ov_cnt++;
    endtask

    // One isolated sample: edge, then three idle cycles until sample_out
    task automatic pulse(input logic [15:0] v);
        snd_in = v;
        sample_in = 1'b1;
        step();
        sample_in = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        k = 0;
        so_cnt = 0;
        ov_cnt = 0;
        last_out[0] = -1;
        last_out[1] = -1;
        rstn = 1'b0;
        snd_in = 16'd0;
        sample_in = 1'b0;
        fxlevel = 2'd1;
        enable = 1'b1;
        model_reset();
        step();
        step();
        check_val("rst_snd_out", snd_out0, 32'd0);
        check_val("rst_flags", {so0, clip0, ov0, so1, clip1, ov1}, 32'd0);
        #2 rstn = 1'b1;

        // Settle with silence while the volume ramps to unity
        for (int i = 0; i < 20; i++) pulse(16'h0000);
        check_val("settle_out", last_out[0], 32'd0);
        check_val("settle_clip", last_clip[0], 32'd0);

        // Step response through the HPF
        pulse(16'h1000);
        check_val("step1_hpf", last_out[0], 32'h1000);
        check_val("step1_byp", last_out[1], 32'h1000);
        pulse(16'h1000);
        check_val("step2_hpf", last_out[0], 32'h0FF0);
        pulse(16'h1000);
        check_val("step3_hpf", last_out[0], 32'h0FE1);

        // Gain levels and saturation on the bypassed path
        fxlevel = 2'd0;
        pulse(16'h1000);
        check_val("fx0_byp", last_out[1], 32'h0800);
        fxlevel = 2'd2;
        pulse(16'h1000);
        check_val("fx2_byp", last_out[1], 32'h1800);
        fxlevel = 2'd3;
        pulse(16'h5000);
        check_val("fx3_pos_byp", last_out[1], 32'h7FFF);
        check_val("fx3_pos_clip", last_clip[1], 32'd1);
        pulse(16'hB000);
        check_val("fx3_neg_byp", last_out[1], 32'h8000);
        check_val("fx3_neg_clip", last_clip[1], 32'd1);

        // Mute ramp down
        fxlevel = 2'd1;
        enable = 1'b0;
        for (int i = 0; i < 18; i++) begin
            pulse(16'h1000);
            check_val($sformatf("ramp_%0d", i), last_out[1], (i < 16) ? 32'((16 - i) * 256) : 32'd0);
        end

        // Edges two clocks apart: second one dropped
        enable = 1'b1;
        so_cnt = 0;
        ov_cnt = 0;
        snd_in = 16'h0200;
        sample_in = 1'b1;
        step();
        sample_in = 1'b0;
        step();
        sample_in = 1'b1;
        step();
        sample_in = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_val("ovr_so_count", so_cnt, 32'd1);
        check_val("ovr_count", ov_cnt, 32'd1);

        // Reset while the sample sits in GAIN
        snd_in = 16'h1234;
        sample_in = 1'b1;
        step();
        sample_in = 1'b0;
        step();
        #2 rstn = 1'b0;
        #1;
        check_val("midrst_snd", {snd_out0, snd_out1}, 32'd0);
        check_val("midrst_flags", {so0, clip0, ov0, so1, clip1, ov1}, 32'd0);
        model_reset();
        so_cnt = 0;
        step();
        rstn = 1'b1;
        step();
        step();
        check_val("midrst_no_so", so_cnt, 32'd0);
        pulse(16'h0400);
        check_val("post_rst_so", so_cnt, 32'd1);
        check_val("post_rst_vol0", last_out[1], 32'd0);
        pulse(16'h0400);
        check_val("post_rst_vol1", last_out[1], 32'h0040);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            sample_in = ($urandom_range(0, 2) == 0);
            snd_in = 16'($urandom);
            if (!pend) begin
                fxlevel = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) enable = ~enable;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
